// File: rtl/stopwatch_core.sv
// stopwatch_core: MM:SS.CC count-up timer with lap capture, countdown with minute/second preset.
// Optional alarm output is built in when STOPWATCH_ALARM_EN is defined.
module stopwatch_core #(
  parameter int unsigned TICK_DIV = 1
`ifdef STOPWATCH_ALARM_EN
  ,
  parameter int unsigned ALARM_LEN = 200
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s0_rst,
  input  logic       s1_start,
  input  logic       s2_stop,
  input  logic       s3_lap,
  input  logic       s4_view,
  input  logic       sw7_cd,
  output logic [5:0] disp_min,
  output logic [5:0] disp_sec,
  output logic [6:0] disp_cs,
  output logic       running,
  output logic       view_lap,
  output logic       lap_valid,
  output logic       ovf,
`ifdef STOPWATCH_ALARM_EN
  output logic       alarm,
`endif
  output logic       cd_done
);

  localparam int unsigned MIN_W = 6;
  localparam int unsigned SEC_W = 6;
  localparam int unsigned CS_W  = 7;
  localparam int unsigned DIV_W = 16;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [MIN_W-1:0] mm;
    logic [SEC_W-1:0] ss;
    logic [CS_W-1:0]  cs;
  } tval_t;

  localparam tval_t T_MAX = '{mm: 6'd59, ss: 6'd59, cs: 7'd99};
  localparam tval_t T_ONE = '{mm: 6'd0,  ss: 6'd0,  cs: 7'd1};

  // Count-up step with carry chain; 59:59.99 wraps to 00:00.00
  function automatic tval_t f_inc(input tval_t t);
    tval_t r;
    r = t;
    if (t.cs != 7'd99) begin
      r.cs = t.cs + 7'd1;
    end else begin
      r.cs = 7'd0;
      if (t.ss != 6'd59) begin
        r.ss = t.ss + 6'd1;
      end else begin
        r.ss = 6'd0;
        r.mm = (t.mm == 6'd59) ? 6'd0 : t.mm + 6'd1;
      end
    end
    return r;
  endfunction

  // Countdown step with borrow chain; never called on 00:00.00
  function automatic tval_t f_dec(input tval_t t);
    tval_t r;
    r = t;
    if (t.cs != 7'd0) begin
      r.cs = t.cs - 7'd1;
    end else begin
      r.cs = 7'd99;
      if (t.ss != 6'd0) begin
        r.ss = t.ss - 6'd1;
      end else begin
        r.ss = 6'd59;
        r.mm = t.mm - 6'd1;
      end
    end
    return r;
  endfunction

  state_t           r_state, w_state;
  logic             r_mode, w_mode;
  tval_t            r_live, w_live;
  tval_t            r_lap, w_lap;
  tval_t            r_disp, w_disp;
  logic [MIN_W-1:0] r_pre_min, w_pre_min;
  logic [SEC_W-1:0] r_pre_sec, w_pre_sec;
  logic             r_lap_valid, w_lap_valid;
  logic             r_view, w_view;
  logic             r_ovf, w_ovf;
  logic             r_cd_done, w_cd_done;
  logic             r_running, w_running;
  logic [DIV_W-1:0] r_div, w_div;
  logic             w_pre_zero;

`ifdef STOPWATCH_ALARM_EN
  localparam int unsigned ALM_W = 16;
  logic             r_alarm, w_alarm;
  logic [ALM_W-1:0] r_alarm_cnt, w_alarm_cnt;
`endif

  assign w_pre_zero = (r_pre_min == 6'd0) && (r_pre_sec == 6'd0);

  // Next-state: divider/tick first, then the single highest-priority pulse
  always_comb begin
    w_state     = r_state;
    w_mode      = (r_state == ST_IDLE) ? sw7_cd : r_mode;
    w_live      = r_live;
    w_lap       = r_lap;
    w_pre_min   = r_pre_min;
    w_pre_sec   = r_pre_sec;
    w_lap_valid = r_lap_valid;
    w_view      = r_view;
    w_ovf       = r_ovf;
    w_div       = r_div;
    w_cd_done   = 1'b0;
`ifdef STOPWATCH_ALARM_EN
    w_alarm     = r_alarm;
    w_alarm_cnt = r_alarm_cnt;
`endif

    if (r_state == ST_RUN && !s0_rst && !s2_stop) begin
      if (r_div == DIV_LAST) begin
        w_div = '0;
        if (!r_mode) begin
          w_live = f_inc(r_live);
          if (r_live == T_MAX) w_ovf = 1'b1;
        end else begin
          w_live = f_dec(r_live);
          if (r_live == T_ONE) begin
            w_state   = ST_DONE;
            w_cd_done = 1'b1;
          end
        end
      end else begin
        w_div = r_div + DIV_W'(1);
      end
    end

`ifdef STOPWATCH_ALARM_EN
    // Alarm length is counted in centisecond ticks on the shared divider
    if (r_state == ST_DONE && r_alarm) begin
      if (r_div == DIV_LAST) begin
        w_div = '0;
        if (r_alarm_cnt == ALM_W'(ALARM_LEN - 1)) w_alarm = 1'b0;
        else w_alarm_cnt = r_alarm_cnt + ALM_W'(1);
      end else begin
        w_div = r_div + DIV_W'(1);
      end
    end
    if (w_cd_done) begin
      w_alarm     = 1'b1;
      w_alarm_cnt = '0;
    end
`endif

    if (s0_rst) begin
      w_state     = ST_IDLE;
      w_live      = '0;
      w_lap       = '0;
      w_pre_min   = '0;
      w_pre_sec   = '0;
      w_lap_valid = 1'b0;
      w_view      = 1'b0;
      w_ovf       = 1'b0;
      w_div       = '0;
      w_cd_done   = 1'b0;
`ifdef STOPWATCH_ALARM_EN
      w_alarm     = 1'b0;
      w_alarm_cnt = '0;
`endif
    end else if (s2_stop) begin
      if (r_state == ST_RUN) w_state = ST_PAUSE;
    end else if (s1_start) begin
      if (r_state == ST_IDLE && !(r_mode && w_pre_zero)) begin
        w_state = ST_RUN;
        w_div   = '0;
        if (r_mode) w_live = tval_t'({r_pre_min, r_pre_sec, 7'd0});
      end else if (r_state == ST_PAUSE) begin
        w_state = ST_RUN;
      end
    end else if (s3_lap) begin
      if (!r_mode && r_state == ST_RUN) begin
        w_lap       = r_live;
        w_lap_valid = 1'b1;
      end else if (r_mode && r_state == ST_IDLE) begin
        w_pre_min = (r_pre_min == 6'd59) ? 6'd0 : r_pre_min + 6'd1;
        w_live    = tval_t'({w_pre_min, r_pre_sec, 7'd0});
      end
    end else if (s4_view) begin
      if (!r_mode) begin
        if (r_lap_valid) w_view = ~r_view;
      end else if (r_state == ST_IDLE) begin
        w_pre_sec = (r_pre_sec == 6'd59) ? 6'd0 : r_pre_sec + 6'd1;
        w_live    = tval_t'({r_pre_min, w_pre_sec, 7'd0});
      end
    end

    if (w_mode) w_view = 1'b0;
    w_disp    = w_view ? w_lap : w_live;
    w_running = (w_state == ST_RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_mode      <= 1'b0;
      r_live      <= '0;
      r_lap       <= '0;
      r_disp      <= '0;
      r_pre_min   <= '0;
      r_pre_sec   <= '0;
      r_lap_valid <= 1'b0;
      r_view      <= 1'b0;
      r_ovf       <= 1'b0;
      r_cd_done   <= 1'b0;
      r_running   <= 1'b0;
      r_div       <= '0;
`ifdef STOPWATCH_ALARM_EN
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
`endif
    end else begin
      r_state     <= w_state;
      r_mode      <= w_mode;
      r_live      <= w_live;
      r_lap       <= w_lap;
      r_disp      <= w_disp;
      r_pre_min   <= w_pre_min;
      r_pre_sec   <= w_pre_sec;
      r_lap_valid <= w_lap_valid;
      r_view      <= w_view;
      r_ovf       <= w_ovf;
      r_cd_done   <= w_cd_done;
      r_running   <= w_running;
      r_div       <= w_div;
`ifdef STOPWATCH_ALARM_EN
      r_alarm     <= w_alarm;
      r_alarm_cnt <= w_alarm_cnt;
`endif
    end
  end

  assign disp_min  = r_disp.mm;
  assign disp_sec  = r_disp.ss;
  assign disp_cs   = r_disp.cs;
  assign running   = r_running;
  assign view_lap  = r_view;
  assign lap_valid = r_lap_valid;
  assign ovf       = r_ovf;
  assign cd_done   = r_cd_done;
`ifdef STOPWATCH_ALARM_EN
  assign alarm     = r_alarm;
`endif

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: two instances (TICK_DIV 1 and 4) checked every cycle against a
// centisecond-integer behavioural model, plus directed literal checks.
module tb_stopwatch_core;

  localparam int IDLE = 0, RUN = 1, PAUSE = 2, DONE = 3;
  localparam int MAXCS = 359999;
  localparam logic [4:0] P_S0 = 5'b00001, P_S1 = 5'b00010, P_S2 = 5'b00100,
                         P_S3 = 5'b01000, P_S4 = 5'b10000;

  logic clk = 1'b0;
  logic rst_n;
  logic s0, s1, s2, s3, s4, sw7;

  logic [5:0] a_min, a_sec, b_min, b_sec;
  logic [6:0] a_cs, b_cs;
  logic a_run, a_vl, a_lv, a_ovf, a_cd;
  logic b_run, b_vl, b_lv, b_ovf, b_cd;

  int n_checks = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  stopwatch_core #(.TICK_DIV(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .s0_rst(s0), .s1_start(s1), .s2_stop(s2),
    .s3_lap(s3), .s4_view(s4), .sw7_cd(sw7),
    .disp_min(a_min), .disp_sec(a_sec), .disp_cs(a_cs), .running(a_run),
    .view_lap(a_vl), .lap_valid(a_lv), .ovf(a_ovf), .cd_done(a_cd));

  stopwatch_core #(.TICK_DIV(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .s0_rst(s0), .s1_start(s1), .s2_stop(s2),
    .s3_lap(s3), .s4_view(s4), .sw7_cd(sw7),
    .disp_min(b_min), .disp_sec(b_sec), .disp_cs(b_cs), .running(b_run),
    .view_lap(b_vl), .lap_valid(b_lv), .ovf(b_ovf), .cd_done(b_cd));

  // Model: times held as plain centisecond counts
  typedef struct {
    int st;
    bit mode;
    int live;
    int lap;
    bit lap_valid;
    bit view;
    bit ovf;
    int pmin;
    int psec;
    int div;
    bit cd_done;
  } mdl_t;

  function automatic mdl_t m_reset();
    mdl_t m;
    m.st = IDLE; m.mode = 0; m.live = 0; m.lap = 0; m.lap_valid = 0; m.view = 0;
    m.ovf = 0; m.pmin = 0; m.psec = 0; m.div = 0; m.cd_done = 0;
    return m;
  endfunction

  function automatic mdl_t m_step(input mdl_t m, input logic [4:0] p, input logic sw, input int td);
    mdl_t n;
    n = m;
    n.cd_done = 0;
    if (m.st == IDLE) n.mode = sw;
    if (m.st == RUN && !p[0] && !p[2]) begin
      if (m.div == td - 1) begin
        n.div = 0;
        if (!m.mode) begin
          if (m.live == MAXCS) begin n.live = 0; n.ovf = 1; end
          else n.live = m.live + 1;
        end else begin
          n.live = m.live - 1;
          if (n.live == 0) begin n.st = DONE; n.cd_done = 1; end
        end
      end else n.div = m.div + 1;
    end
    if (p[0]) begin
      n.st = IDLE; n.live = 0; n.lap = 0; n.pmin = 0; n.psec = 0;
      n.lap_valid = 0; n.view = 0; n.ovf = 0; n.div = 0; n.cd_done = 0;
    end else if (p[2]) begin
      if (m.st == RUN) n.st = PAUSE;
    end else if (p[1]) begin
      if (m.st == IDLE && !(m.mode && m.pmin == 0 && m.psec == 0)) begin
        n.st = RUN; n.div = 0;
        if (m.mode) n.live = (m.pmin * 60 + m.psec) * 100;
      end else if (m.st == PAUSE) n.st = RUN;
    end else if (p[3]) begin
      if (!m.mode && m.st == RUN) begin n.lap = m.live; n.lap_valid = 1; end
      else if (m.mode && m.st == IDLE) begin
        n.pmin = (m.pmin + 1) % 60;
        n.live = (n.pmin * 60 + m.psec) * 100;
      end
    end else if (p[4]) begin
      if (!m.mode) begin
        if (m.lap_valid) n.view = !m.view;
      end else if (m.st == IDLE) begin
        n.psec = (m.psec + 1) % 60;
        n.live = (m.pmin * 60 + n.psec) * 100;
      end
    end
    if (n.mode) n.view = 0;
    return n;
  endfunction

  mdl_t ma, mb;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ma <= m_reset();
      mb <= m_reset();
    end else begin
      ma <= m_step(ma, {s4, s3, s2, s1, s0}, sw7, 1);
      mb <= m_step(mb, {s4, s3, s2, s1, s0}, sw7, 4);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string tag, input mdl_t m, input logic [5:0] dm, input logic [5:0] ds,
                     input logic [6:0] dc, input logic run, input logic vl, input logic lv,
                     input logic ov, input logic cd);
    int v;
    v = m.view ? m.lap : m.live;
    chk({tag, ".min"}, 32'(dm), 32'(v / 6000));
    chk({tag, ".sec"}, 32'(ds), 32'((v / 100) % 60));
    chk({tag, ".cs"}, 32'(dc), 32'(v % 100));
    chk({tag, ".running"}, 32'(run), 32'(m.st == RUN));
    chk({tag, ".view_lap"}, 32'(vl), 32'(m.view));
    chk({tag, ".lap_valid"}, 32'(lv), 32'(m.lap_valid));
    chk({tag, ".ovf"}, 32'(ov), 32'(m.ovf));
    chk({tag, ".cd_done"}, 32'(cd), 32'(m.cd_done));
  endtask

  // Advance one cycle and compare both instances against the model
  task automatic step_cmp();
    @(negedge clk);
    if (rst_n === 1'b1) begin
      cmp("a", ma, a_min, a_sec, a_cs, a_run, a_vl, a_lv, a_ovf, a_cd);
      cmp("b", mb, b_min, b_sec, b_cs, b_run, b_vl, b_lv, b_ovf, b_cd);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) step_cmp();
  endtask

  task automatic pulse(input logic [4:0] p);
    {s4, s3, s2, s1, s0} = p;
    step_cmp();
    {s4, s3, s2, s1, s0} = 5'b0;
  endtask

  task automatic chk_a(input string nm, input int mm, input int ss, input int cc);
    chk({nm, ".a_min"}, 32'(a_min), 32'(mm));
    chk({nm, ".a_sec"}, 32'(a_sec), 32'(ss));
    chk({nm, ".a_cs"}, 32'(a_cs), 32'(cc));
  endtask

  task automatic chk_b(input string nm, input int mm, input int ss, input int cc);
    chk({nm, ".b_min"}, 32'(b_min), 32'(mm));
    chk({nm, ".b_sec"}, 32'(b_sec), 32'(ss));
    chk({nm, ".b_cs"}, 32'(b_cs), 32'(cc));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {s4, s3, s2, s1, s0} = 5'b0;
    sw7 = 1'b0;
    repeat (3) @(negedge clk);
    chk_a("reset", 0, 0, 0);
    chk("reset.running", 32'(a_run), 0);
    chk("reset.flags", 32'({a_vl, a_lv, a_ovf, a_cd}), 0);
    rst_n = 1'b1;
    wait_clks(2);

    // Count-up, pause, resume
    pulse(P_S1);
    wait_clks(6123);
    pulse(P_S2);
    wait_clks(50);
    chk_a("pause", 1, 1, 23);
    chk("pause.running", 32'(a_run), 0);
    pulse(P_S1);
    wait_clks(77);
    chk_a("resume", 1, 2, 0);
    chk_b("resume4", 0, 15, 50);

    // Lap and view
    pulse(P_S0);
    pulse(P_S4);
    chk("nolap.view_lap", 32'(a_vl), 0);
    pulse(P_S1);
    wait_clks(250);
    pulse(P_S3);
    chk("lap.lap_valid", 32'(a_lv), 1);
    chk_a("lap_live", 0, 2, 51);
    pulse(P_S4);
    chk("view.view_lap", 32'(a_vl), 1);
    chk_a("view_lap", 0, 2, 50);
    wait_clks(10);
    chk_a("view_hold", 0, 2, 50);
    pulse(P_S4);
    chk("view_off.view_lap", 32'(a_vl), 0);
    chk_a("view_off", 0, 2, 63);

    // Asynchronous reset mid-RUN
    pulse(P_S0);
    pulse(P_S1);
    wait_clks(150);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_a("async_rst", 0, 0, 0);
    chk_b("async_rst", 0, 0, 0);
    chk("async_rst.running", 32'({a_run, b_run}), 0);
    chk("async_rst.flags", 32'({a_vl, a_lv, a_ovf, a_cd}), 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clks(2);

    // Wrap: preset 59:59 in countdown IDLE, then count up from it
    sw7 = 1'b1;
    wait_clks(1);
    repeat (59) pulse(P_S3);
    repeat (59) pulse(P_S4);
    chk_a("preset_max", 59, 59, 0);
    sw7 = 1'b0;
    wait_clks(1);
    pulse(P_S1);
    wait_clks(99);
    chk_a("at_max", 59, 59, 99);
    chk("at_max.ovf", 32'(a_ovf), 0);
    wait_clks(1);
    chk_a("wrap", 0, 0, 0);
    chk("wrap.ovf", 32'(a_ovf), 1);
    chk("wrap.running", 32'(a_run), 1);
    pulse(P_S0);
    chk("wrap_clr.ovf", 32'(a_ovf), 0);

    // Countdown from 02:03.00
    sw7 = 1'b1;
    wait_clks(1);
    repeat (2) pulse(P_S3);
    repeat (3) pulse(P_S4);
    chk_a("cd_preset", 2, 3, 0);
    pulse(P_S1);
    wait_clks(12299);
    chk_a("cd_last", 0, 0, 1);
    chk("cd_last.cd_done", 32'(a_cd), 0);
    wait_clks(1);
    chk_a("cd_zero", 0, 0, 0);
    chk("cd_zero.cd_done", 32'(a_cd), 1);
    chk("cd_zero.running", 32'(a_run), 0);
    wait_clks(1);
    chk("cd_pulse_end.cd_done", 32'(a_cd), 0);
    pulse(P_S1);
    chk("done_s1.running", 32'(a_run), 0);
    pulse(P_S0);
    pulse(P_S1);
    chk("cd_zero_preset.running", 32'(a_run), 0);

    // Simultaneous s1+s2 from PAUSE
    sw7 = 1'b0;
    wait_clks(1);
    pulse(P_S1);
    wait_clks(5);
    pulse(P_S2);
    pulse(P_S1 | P_S2);
    chk("s1s2.running", 32'(a_run), 0);
    pulse(P_S1);
    chk("s1_resume.running", 32'(a_run), 1);

    // Divider position survives pause (TICK_DIV=4 paused at divider 2)
    pulse(P_S0);
    pulse(P_S1);
    wait_clks(6);
    chk_b("div_run", 0, 0, 1);
    pulse(P_S2);
    wait_clks(3);
    pulse(P_S1);
    wait_clks(1);
    chk_b("div_res1", 0, 0, 1);
    wait_clks(1);
    chk_b("div_res2", 0, 0, 2);
    chk_a("div_a", 0, 0, 8);

    // Randomized traffic
    pulse(P_S0);
    for (int i = 0; i < 4000; i++) begin
      s0 = ($urandom_range(0, 99) == 0);
      s1 = ($urandom_range(0, 7) == 0);
      s2 = ($urandom_range(0, 7) == 0);
      s3 = ($urandom_range(0, 7) == 0);
      s4 = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 49) == 0) sw7 = ~sw7;
      step_cmp();
    end
    {s4, s3, s2, s1, s0} = 5'b0;
    wait_clks(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
